// File: rtl/vga_color_reducer.sv
// vga_color_reducer: VGA output stage that reduces IN_BITS-per-channel RGB to
// OUT_BITS-per-channel ahead of a resistor-ladder DAC. Two register stages,
// with colour, DE and both syncs kept aligned at a fixed latency of 2 cycles.
//
// Build option VGA_DITHER_EN: when defined, a 4x4 ordered (Bayer) threshold
// is added before truncation. The pixel position comes from DE/VSYNC timing.
// When undefined, the output is plain truncation and the position tracking
// and Bayer table are omitted. Latency is 2 cycles in both builds.
module vga_color_reducer #(
    parameter int IN_BITS          = 8,
    parameter int OUT_BITS         = 4,
    parameter bit VSYNC_ACTIVE_LOW = 1'b1,
    parameter bit HSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic                CLK_25MHZ,
    input  logic                RESET_N,
    input  logic                DE_IN,
    input  logic                VGA_HSYNC_IN,
    input  logic                VGA_VSYNC_IN,
    input  logic [IN_BITS-1:0]  RED_IN,
    input  logic [IN_BITS-1:0]  GREEN_IN,
    input  logic [IN_BITS-1:0]  BLUE_IN,
    output logic                DE_OUT,
    output logic                VGA_HSYNC,
    output logic                VGA_VSYNC,
    output logic [OUT_BITS-1:0] VGA_RED,
    output logic [OUT_BITS-1:0] VGA_GREEN,
    output logic [OUT_BITS-1:0] VGA_BLUE
);

    localparam int   DROP    = IN_BITS - OUT_BITS;
    // Deasserted sync level, used as the reset value of every sync register.
    localparam logic HS_IDLE = HSYNC_ACTIVE_LOW;
    localparam logic VS_IDLE = VSYNC_ACTIVE_LOW;

    logic               de_s1;
    logic               hs_s1;
    logic               vs_s1;
    logic [IN_BITS-1:0] red_s1;
    logic [IN_BITS-1:0] green_s1;
    logic [IN_BITS-1:0] blue_s1;

    logic [OUT_BITS-1:0] red_q;
    logic [OUT_BITS-1:0] green_q;
    logic [OUT_BITS-1:0] blue_q;

`ifdef VGA_DITHER_EN
    // The threshold is b scaled to DROP bits: b*2^DROP/16, done as a left and
    // a right shift so neither shift amount can go negative.
    localparam int SH_L = (DROP >= 4) ? DROP - 4 : 0;
    localparam int SH_R = (DROP < 4) ? 4 - DROP : 0;
    localparam int TW   = IN_BITS + 5;

    logic [1:0] pos_x;
    logic [1:0] pos_y;
    logic [3:0] b_s1;
    logic       de_fall;
    logic       vs_assert;

    function automatic logic [3:0] bayer4(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] v;
        case ({row, col})
            4'd0:  v = 4'd0;   4'd1:  v = 4'd8;   4'd2:  v = 4'd2;   4'd3:  v = 4'd10;
            4'd4:  v = 4'd12;  4'd5:  v = 4'd4;   4'd6:  v = 4'd14;  4'd7:  v = 4'd6;
            4'd8:  v = 4'd3;   4'd9:  v = 4'd11;  4'd10: v = 4'd1;   4'd11: v = 4'd9;
            4'd12: v = 4'd15;  4'd13: v = 4'd7;   4'd14: v = 4'd13;  default: v = 4'd5;
        endcase
        return v;
    endfunction

    // Add the threshold, then saturate on carry-out rather than wrapping to 0.
    function automatic logic [OUT_BITS-1:0] chan_reduce(input logic [IN_BITS-1:0] c,
                                                        input logic [3:0] b);
        logic [TW-1:0] t;
        logic [TW-1:0] sum;
        t   = ({{(TW-4){1'b0}}, b} << SH_L) >> SH_R;
        sum = {5'b0, c} + t;
        if (sum[IN_BITS]) return '1;
        return sum[IN_BITS-1:DROP];
    endfunction

    // Edges are taken against the stage-1 copies, so nothing seen during reset
    // counts as an edge.
    assign de_fall   = de_s1 & ~DE_IN;
    assign vs_assert = (VGA_VSYNC_IN != VS_IDLE) && (vs_s1 == VS_IDLE);

    // Screen position mod 4; a VSYNC assertion beats an end-of-line increment.
    always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            pos_x <= 2'd0;
            pos_y <= 2'd0;
            b_s1  <= 4'd0;
        end else begin
            pos_x <= DE_IN ? pos_x + 2'd1 : 2'd0;
            if (vs_assert)
                pos_y <= 2'd0;
            else if (de_fall)
                pos_y <= pos_y + 2'd1;
            b_s1 <= bayer4(pos_y, pos_x);
        end
    end

    assign red_q   = chan_reduce(red_s1, b_s1);
    assign green_q = chan_reduce(green_s1, b_s1);
    assign blue_q  = chan_reduce(blue_s1, b_s1);
`else
    assign red_q   = red_s1[IN_BITS-1:DROP];
    assign green_q = green_s1[IN_BITS-1:DROP];
    assign blue_q  = blue_s1[IN_BITS-1:DROP];
`endif

    // Stage 1: capture the pixel, DE and syncs.
    always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            de_s1    <= 1'b0;
            hs_s1    <= HS_IDLE;
            vs_s1    <= VS_IDLE;
            red_s1   <= '0;
            green_s1 <= '0;
            blue_s1  <= '0;
        end else begin
            de_s1    <= DE_IN;
            hs_s1    <= VGA_HSYNC_IN;
            vs_s1    <= VGA_VSYNC_IN;
            red_s1   <= RED_IN;
            green_s1 <= GREEN_IN;
            blue_s1  <= BLUE_IN;
        end
    end

    // Stage 2: register the reduced colour, forced to black outside active video.
    always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            DE_OUT    <= 1'b0;
            VGA_HSYNC <= HS_IDLE;
            VGA_VSYNC <= VS_IDLE;
            VGA_RED   <= '0;
            VGA_GREEN <= '0;
            VGA_BLUE  <= '0;
        end else begin
            DE_OUT    <= de_s1;
            VGA_HSYNC <= hs_s1;
            VGA_VSYNC <= vs_s1;
            VGA_RED   <= de_s1 ? red_q : '0;
            VGA_GREEN <= de_s1 ? green_q : '0;
            VGA_BLUE  <= de_s1 ? blue_q : '0;
        end
    end

endmodule

// File: tb/tb_vga_color_reducer.sv
// Testbench for vga_color_reducer: four instances (OUT_BITS 4/8/5/1 and mixed
// sync polarities) share one randomized VGA-like stimulus stream and are
// compared every cycle against an arithmetic reference model.
module tb_vga_color_reducer;

    localparam int N = 4;
    localparam int OB  [N] = '{4, 8, 5, 1};
    localparam int HAL [N] = '{1, 0, 1, 1};
    localparam int VAL [N] = '{1, 1, 1, 0};
    localparam int BAYER [16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};

    typedef struct {
        int de; int hs; int vs; int r; int g; int b;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       de_in, hs_in, vs_in;
    logic [7:0] r_in, g_in, b_in;

    logic       de_o [N];
    logic       hs_o [N];
    logic       vs_o [N];
    logic [3:0] r0, g0, b0;
    logic [7:0] r1, g1, b1;
    logic [4:0] r2, g2, b2;
    logic [0:0] r3, g3, b3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_color_reducer u0 (
        .CLK_25MHZ(clk), .RESET_N(rst_n), .DE_IN(de_in), .VGA_HSYNC_IN(hs_in),
        .VGA_VSYNC_IN(vs_in), .RED_IN(r_in), .GREEN_IN(g_in), .BLUE_IN(b_in),
        .DE_OUT(de_o[0]), .VGA_HSYNC(hs_o[0]), .VGA_VSYNC(vs_o[0]),
        .VGA_RED(r0), .VGA_GREEN(g0), .VGA_BLUE(b0));

    vga_color_reducer #(.OUT_BITS(8), .HSYNC_ACTIVE_LOW(1'b0)) u1 (
        .CLK_25MHZ(clk), .RESET_N(rst_n), .DE_IN(de_in), .VGA_HSYNC_IN(hs_in),
        .VGA_VSYNC_IN(vs_in), .RED_IN(r_in), .GREEN_IN(g_in), .BLUE_IN(b_in),
        .DE_OUT(de_o[1]), .VGA_HSYNC(hs_o[1]), .VGA_VSYNC(vs_o[1]),
        .VGA_RED(r1), .VGA_GREEN(g1), .VGA_BLUE(b1));

    vga_color_reducer #(.OUT_BITS(5)) u2 (
        .CLK_25MHZ(clk), .RESET_N(rst_n), .DE_IN(de_in), .VGA_HSYNC_IN(hs_in),
        .VGA_VSYNC_IN(vs_in), .RED_IN(r_in), .GREEN_IN(g_in), .BLUE_IN(b_in),
        .DE_OUT(de_o[2]), .VGA_HSYNC(hs_o[2]), .VGA_VSYNC(vs_o[2]),
        .VGA_RED(r2), .VGA_GREEN(g2), .VGA_BLUE(b2));

    vga_color_reducer #(.OUT_BITS(1), .VSYNC_ACTIVE_LOW(1'b0)) u3 (
        .CLK_25MHZ(clk), .RESET_N(rst_n), .DE_IN(de_in), .VGA_HSYNC_IN(hs_in),
        .VGA_VSYNC_IN(vs_in), .RED_IN(r_in), .GREEN_IN(g_in), .BLUE_IN(b_in),
        .DE_OUT(de_o[3]), .VGA_HSYNC(hs_o[3]), .VGA_VSYNC(vs_o[3]),
        .VGA_RED(r3), .VGA_GREEN(g3), .VGA_BLUE(b3));

    int ar [N];
    int ag [N];
    int ab [N];
    always_comb begin
        ar[0] = int'(r0); ag[0] = int'(g0); ab[0] = int'(b0);
        ar[1] = int'(r1); ag[1] = int'(g1); ab[1] = int'(b1);
        ar[2] = int'(r2); ag[2] = int'(g2); ab[2] = int'(b2);
        ar[3] = int'(r3); ag[3] = int'(g3); ab[3] = int'(b3);
    end

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: one channel, 8 input bits, from the threshold/saturate rules.
    function automatic int model_chan(input int c, input int bay, input int ob);
        int drop;
        int t;
        int s;
        drop = 8 - ob;
        t = 0;
`ifdef VGA_DITHER_EN
        if (drop == 0)     t = 0;
        else if (drop < 4) t = bay / (1 << (4 - drop));
        else               t = bay * (1 << (drop - 4));
`endif
        s = c + t;
        if (s > 255) return (1 << ob) - 1;
        return s / (1 << drop);
    endfunction

    function automatic exp_t idle_of(input int i);
        exp_t e;
        e.de = 0; e.hs = HAL[i]; e.vs = VAL[i]; e.r = 0; e.g = 0; e.b = 0;
        return e;
    endfunction

    // Model state: position per instance (vsync polarity differs), two-deep delay line.
    exp_t d1 [N];
    exp_t d2 [N];
    int   mx [N];
    int   my [N];
    int   pva [N];
    int   pde;

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            int asserted;
            int bay;
            if (!rst_n) begin
                mx[i] = 0; my[i] = 0; pva[i] = 0;
                d1[i] = idle_of(i); d2[i] = idle_of(i);
            end else begin
                d2[i] = d1[i];
                bay = BAYER[my[i] * 4 + mx[i]];
                d1[i].de = int'(de_in);
                d1[i].hs = int'(hs_in);
                d1[i].vs = int'(vs_in);
                d1[i].r  = de_in ? model_chan(int'(r_in), bay, OB[i]) : 0;
                d1[i].g  = de_in ? model_chan(int'(g_in), bay, OB[i]) : 0;
                d1[i].b  = de_in ? model_chan(int'(b_in), bay, OB[i]) : 0;
                asserted = (VAL[i] != 0) ? int'(!vs_in) : int'(vs_in);
                if (asserted != 0 && pva[i] == 0) my[i] = 0;
                else if (pde != 0 && !de_in)       my[i] = (my[i] + 1) % 4;
                mx[i]  = de_in ? (mx[i] + 1) % 4 : 0;
                pva[i] = asserted;
            end
        end
        pde = rst_n ? int'(de_in) : 0;
    end

    // Hand-computed expectations for instance u0, packed {r,g,b} per active pixel.
    int lit_q [$];
    logic lit_en = 1'b0;

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            exp_t e;
            e = rst_n ? d2[i] : idle_of(i);
            chk($sformatf("u%0d_de", i), int'(de_o[i]), e.de);
            chk($sformatf("u%0d_hsync", i), int'(hs_o[i]), e.hs);
            chk($sformatf("u%0d_vsync", i), int'(vs_o[i]), e.vs);
            chk($sformatf("u%0d_red", i), ar[i], e.r);
            chk($sformatf("u%0d_green", i), ag[i], e.g);
            chk($sformatf("u%0d_blue", i), ab[i], e.b);
        end
        if (lit_en && rst_n && de_o[0]) begin
            if (lit_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL lit_extra_pixel: got rgb %0h, required no active pixel", {r0, g0, b0});
            end else begin
                chk("lit_rgb", int'({r0, g0, b0}), lit_q.pop_front());
            end
        end
    end

    task automatic cyc(input logic de, input logic hs, input logic vs,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        @(posedge clk);
        #2;
        de_in = de; hs_in = hs; vs_in = vs; r_in = r; g_in = g; b_in = b;
    endtask

    task automatic pix(input logic [7:0] v, input int req);
        cyc(1'b1, 1'b1, 1'b1, v, v, v);
        lit_q.push_back((req << 8) | (req << 4) | req);
    endtask

    function automatic logic [7:0] rc();
        case ($urandom_range(0, 7))
            0: return 8'h00;
            1: return 8'hFF;
            2: return 8'hF8;
            3: return 8'hFC;
            4: return 8'h80;
            5: return 8'h08;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        de_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
        r_in = 8'h00; g_in = 8'h00; b_in = 8'h00;

        // Arbitrary inputs under reset must not reach the outputs.
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'($urandom), 1'($urandom), rc(), rc(), rc());
        @(negedge clk);
        chk("rst_red", int'(r0), 0);
        chk("rst_de", int'(de_o[0]), 0);
        chk("rst_hsync_low_active", int'(hs_o[0]), 1);
        chk("rst_vsync_low_active", int'(vs_o[0]), 1);
        chk("rst_hsync_high_active", int'(hs_o[1]), 0);
        chk("rst_vsync_high_active", int'(vs_o[3]), 0);

        cyc(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
        @(posedge clk);
        #2 rst_n = 1'b1;
        lit_en = 1'b1;
        pix(8'hF0, 4'hF);
        lit_q[lit_q.size() - 1] = 12'hF00;
        r_in = 8'hF0; g_in = 8'h00; b_in = 8'h00;
        for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);

`ifdef VGA_DITHER_EN
        // y is 1 after the first line; x restarts at 0.
        pix(8'h08, 1); pix(8'h08, 0); pix(8'h08, 1);
        // DE falls in the same cycle VSYNC asserts: y must read 0 afterwards.
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        cyc(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
        pix(8'h08, 0); pix(8'h08, 1);
        cyc(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
        // 4x4 pattern from a fresh VSYNC edge; F8 at b=8 and FF at b=15 saturate.
        cyc(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
        cyc(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
        pix(8'h08, 0); pix(8'hF8, 15); pix(8'h08, 0); pix(8'h08, 1);
        cyc(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
        pix(8'h08, 1); pix(8'h08, 0); pix(8'h08, 1); pix(8'h08, 0);
        cyc(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
        pix(8'h08, 0); pix(8'h08, 1); pix(8'h08, 0); pix(8'h08, 1);
        cyc(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
        pix(8'hFF, 15); pix(8'h08, 0); pix(8'h08, 1); pix(8'h08, 0);
`else
        cyc(1'b1, 1'b1, 1'b1, 8'h7F, 8'h80, 8'h0F);
        lit_q.push_back(12'h780);
        pix(8'hFF, 15);
        pix(8'hF8, 15);
        pix(8'h08, 0);
        cyc(1'b0, 1'b1, 1'b1, 8'h7F, 8'h80, 8'h0F);
        pix(8'h10, 1);
`endif
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);
        if (lit_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL lit_missing_pixels: got %0d unmatched, required 0", lit_q.size());
        end
        lit_en = 1'b0;

        // Randomized frames with hsync/vsync pulses, occasional coincident edges.
        for (int f = 0; f < 10; f++) begin
            cyc(1'b0, 1'b1, 1'b0, rc(), rc(), rc());
            cyc(1'b0, 1'b1, 1'b0, rc(), rc(), rc());
            cyc(1'b0, 1'b1, 1'b1, rc(), rc(), rc());
            for (int l = 0; l < 8; l++) begin
                int len;
                len = $urandom_range(2, 9);
                for (int p = 0; p < len; p++) cyc(1'b1, 1'b1, 1'b1, rc(), rc(), rc());
                if ($urandom_range(0, 5) == 0) cyc(1'b0, 1'b1, 1'b0, rc(), rc(), rc());
                else cyc(1'b0, 1'b0, 1'b1, rc(), rc(), rc());
                cyc(1'b0, 1'b1, 1'b1, rc(), rc(), rc());
                if (f == 4 && l == 3) begin
                    for (int p = 0; p < 3; p++) cyc(1'b1, 1'b1, 1'b1, rc(), rc(), rc());
                    @(posedge clk);
                    #3 rst_n = 1'b0;
                    #1;
                    chk("async_rst_de", int'(de_o[0]), 0);
                    chk("async_rst_red", int'(r1), 0);
                    chk("async_rst_hsync", int'(hs_o[1]), 0);
                    @(posedge clk);
                    @(posedge clk);
                    #2 rst_n = 1'b1;
                end
            end
        end
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
